uart_packet_decoder: RTL and testbench
======================================

# uart_packet_decoder

Byte-stream framer directly downstream of the UART receiver in the multiplayer link. Consumes received bytes (data plus one-cycle done strobe), hunts for a sync byte, and assembles a fixed-length frame: type byte, payload, XOR checksum. Validated frames are presented to the game logic as one parallel word with a one-cycle valid pulse. Checksum failures and inter-byte timeouts are flagged and discarded.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- PAYLOAD_BYTES, 4, payload length in bytes (1..8)
- TIMEOUT_CYCLES, 50000, max clocks between bytes inside a frame (≥2)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_done_tick  input  1  one-cycle strobe: din holds a new byte
- din  input  8  received byte, valid only with rx_done_tick
- pkt_valid  output  1  one-cycle pulse: new frame on pkt_type/pkt_data
- pkt_type  output  8  type byte of last good frame
- pkt_data  output  8*PAYLOAD_BYTES  payload of last good frame, first byte in MSBs
- chk_err_tick  output  1  one-cycle pulse: checksum mismatch
- timeout_tick  output  1  one-cycle pulse: frame abandoned on gap timeout

## Operation
- States: HUNT, TYPE, DATA, CHECK. Transitions happen only on rx_done_tick, except timeout.
- HUNT: byte == SYNC_BYTE -> TYPE; any other byte discarded.
- TYPE: store byte in type shadow reg, init checksum acc = byte, byte counter = 0 -> DATA.
- DATA: shift byte into payload shadow reg (left shift, new byte in LSBs), acc ^= byte. Counter == PAYLOAD_BYTES-1 -> CHECK, else counter+1.
- CHECK: byte == acc -> copy shadows to pkt_type/pkt_data, pulse pkt_valid. Mismatch -> pulse chk_err_tick, outputs unchanged. Both cases -> HUNT.
- SYNC_BYTE inside TYPE/DATA/CHECK is ordinary data. No resync mid-frame.
- Gap timer: cleared on every rx_done_tick and in HUNT. Increments each clock in TYPE/DATA/CHECK. Reaching TIMEOUT_CYCLES-1 without a byte -> HUNT, pulse timeout_tick, shadows discarded.
- Byte and timer expiry in the same cycle: the byte wins. It is processed normally, the timer clears, and no timeout_tick.
- Checksum is XOR of the type byte and all payload bytes. The sync byte is excluded.

## Timing
- Reset (async assert, sync deassert handled upstream): state HUNT, counter/timer/acc/shadows 0, pkt_type 0, pkt_data 0, pkt_valid 0, chk_err_tick 0, timeout_tick 0.
- Reset mid-frame: partial frame lost. pkt_* return to 0.
- All outputs registered. pkt_valid/chk_err_tick rise in the cycle after the rx_done_tick carrying the checksum byte. Width is exactly one clock.
- pkt_type/pkt_data update in the same edge as pkt_valid rises. They hold until the next good frame.
- timeout_tick rises one cycle after the expiry condition.
- Back-to-back bytes on consecutive clocks are accepted; no backpressure, no bytes dropped.
- Minimum frame: PAYLOAD_BYTES+3 bytes. A sync byte may immediately follow a checksum byte.

## Structure
- Shared package uart_pkg: state encoding localparams, default SYNC_BYTE, checksum-width constant. The same constants are reused by the future transmit-side packet builder.
- One sub-module: uart_gap_timer (clear, enable, expiry pulse; width = clog2(TIMEOUT_CYCLES)). Framer FSM, shadow regs and checksum stay in the top.

## Test plan
- Good frame A5 01 12 34 56 78 09, bytes every 16 clocks -> one pkt_valid; pkt_type=01, pkt_data=0x12345678; no error pulses.
- Leading junk 00 FF 5A then the frame above -> junk ignored, same single pkt_valid and values.
- Same frame with checksum 0x08 -> chk_err_tick once, pkt_valid 0, outputs keep previous values. Following good frame A5 02 00 00 00 A5 A7 decodes: type 02, data 0x000000A5.
- A5 01 12 then silence > TIMEOUT_CYCLES (set 100) -> timeout_tick after 100 idle clocks. Then a complete frame decodes correctly.
- Byte strobe in the exact cycle of timer expiry -> no timeout_tick, frame completes. Back-to-back strobes every clock for a full frame -> decoded.
- Assert reset between payload bytes 2 and 3 -> all outputs 0 asynchronously. The rest of the frame is ignored until the next A5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART packet link (receive-side framer and the
// transmit-side packet builder).
//   - Framer state encoding and the enum built on it.
//   - Default sync byte that marks the start of every frame.
//   - Checksum width and the running-checksum update rule.
package uart_pkg;

  localparam logic [1:0] ST_HUNT_ENC  = 2'd0;
  localparam logic [1:0] ST_TYPE_ENC  = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_CHECK_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_HUNT  = ST_HUNT_ENC,
    S_TYPE  = ST_TYPE_ENC,
    S_DATA  = ST_DATA_ENC,
    S_CHECK = ST_CHECK_ENC
  } frame_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         CHK_W             = 8;

  // Running checksum: XOR of the type byte and every payload byte.
  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer for the packet framer.
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : restart the count (a byte arrived, or the framer is idle)
//   enable     : count one per clock while a frame is in progress
//   expired    : high during the cycle in which the count sits at
//                TIMEOUT_CYCLES-1 with no clear; the count then restarts
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // A clear in the expiry cycle suppresses the expiry: an arriving byte wins.
  assign expired = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear || expired) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Byte-stream framer behind the UART receiver.
// Frame on the wire: SYNC, TYPE, PAYLOAD_BYTES payload bytes, CHECKSUM,
// where CHECKSUM = TYPE ^ payload bytes (sync excluded).
//   clk, reset    : system clock, asynchronous active-high reset
//   rx_done_tick  : one-cycle strobe, din holds a new byte
//   din           : received byte
//   pkt_valid     : one-cycle pulse, new frame on pkt_type / pkt_data
//   pkt_type      : type byte of the last good frame
//   pkt_data      : payload of the last good frame, first byte in the MSBs
//   chk_err_tick  : one-cycle pulse, checksum mismatch (frame dropped)
//   timeout_tick  : one-cycle pulse, frame abandoned on an inter-byte gap
module uart_packet_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         PAYLOAD_BYTES  = 4,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_done_tick,
  input  logic [7:0]                   din,
  output logic                         pkt_valid,
  output logic [7:0]                   pkt_type,
  output logic [8*PAYLOAD_BYTES-1:0]   pkt_data,
  output logic                         chk_err_tick,
  output logic                         timeout_tick
);

  localparam int                DATA_W   = 8 * PAYLOAD_BYTES;
  localparam int                CNT_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  frame_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHK_W-1:0]   acc_q, acc_d;
  logic [7:0]         type_sh_q, type_sh_d;
  logic [DATA_W-1:0]  data_sh_q, data_sh_d;
  logic [7:0]         pkt_type_q, pkt_type_d;
  logic [DATA_W-1:0]  pkt_data_q, pkt_data_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               chk_err_q, chk_err_d;
  logic               timeout_q, timeout_d;

  logic gap_expired;

  // The timer only runs while a frame is open and restarts on every byte.
  uart_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_done_tick || (state_q == S_HUNT)),
    .enable  (state_q != S_HUNT),
    .expired (gap_expired)
  );

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    type_sh_d   = type_sh_q;
    data_sh_d   = data_sh_q;
    pkt_type_d  = pkt_type_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = 1'b0;
    chk_err_d   = 1'b0;
    timeout_d   = 1'b0;

    if (rx_done_tick) begin
      unique case (state_q)
        S_HUNT: begin
          if (din == SYNC_BYTE) state_d = S_TYPE;
        end
        S_TYPE: begin
          type_sh_d = din;
          acc_d     = din;
          cnt_d     = '0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          // Earlier bytes move toward the MSBs so the first one ends on top.
          data_sh_d = (data_sh_q << 8) | DATA_W'(din);
          acc_d     = chk_update(acc_q, din);
          if (cnt_q == LAST_IDX) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (din == acc_q) begin
            pkt_type_d  = type_sh_q;
            pkt_data_d  = data_sh_q;
            pkt_valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end else if (gap_expired) begin
      state_d   = S_HUNT;
      timeout_d = 1'b1;
      cnt_d     = '0;
      acc_d     = '0;
      type_sh_d = '0;
      data_sh_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HUNT;
      cnt_q       <= '0;
      acc_q       <= '0;
      type_sh_q   <= '0;
      data_sh_q   <= '0;
      pkt_type_q  <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      type_sh_q   <= type_sh_d;
      data_sh_q   <= data_sh_d;
      pkt_type_q  <= pkt_type_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      chk_err_q   <= chk_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pkt_valid    = pkt_valid_q;
  assign pkt_type     = pkt_type_q;
  assign pkt_data     = pkt_data_q;
  assign chk_err_tick = chk_err_q;
  assign timeout_tick = timeout_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Self-checking bench for uart_packet_decoder (PAYLOAD_BYTES=4,
// TIMEOUT_CYCLES=100). Inputs change on the falling edge; pulse outputs are
// counted on the rising edge (pre-update values) and read on the falling edge.
module tb_uart_packet_decoder;

  localparam int P  = 4;
  localparam int T  = 100;
  localparam int DW = 8 * P;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done_tick;
  logic [7:0]    din;
  logic          pkt_valid;
  logic [7:0]    pkt_type;
  logic [DW-1:0] pkt_data;
  logic          chk_err_tick;
  logic          timeout_tick;

  int tests_run = 0;
  int fails     = 0;
  int n_valid   = 0;
  int n_err     = 0;
  int n_tmo     = 0;

  uart_packet_decoder #(
    .SYNC_BYTE      (8'hA5),
    .PAYLOAD_BYTES  (P),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .din          (din),
    .pkt_valid    (pkt_valid),
    .pkt_type     (pkt_type),
    .pkt_data     (pkt_data),
    .chk_err_tick (chk_err_tick),
    .timeout_tick (timeout_tick)
  );

  always #5 clk = ~clk;

  // Each high cycle is counted, so a stretched pulse shows up as an extra event.
  always @(posedge clk) begin
    if (pkt_valid === 1'b1)    n_valid++;
    if (chk_err_tick === 1'b1) n_err++;
    if (timeout_tick === 1'b1) n_tmo++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] model_chk(input logic [7:0] t, input logic [DW-1:0] d);
    logic [7:0] c;
    c = t;
    for (int i = 0; i < P; i++) c = c ^ d[8*i +: 8];
    return c;
  endfunction

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic strobe(input logic [7:0] b);
    din          = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    din          = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Byte strobes spaced 'gap' clocks apart (gap=1 means consecutive clocks).
  task automatic send_frame(input logic [7:0] t, input logic [DW-1:0] d,
                            input logic [7:0] c, input int gap);
    logic [7:0] seq[$];
    seq.push_back(8'hA5);
    seq.push_back(t);
    for (int i = 0; i < P; i++) seq.push_back(d[DW-1-8*i -: 8]);
    seq.push_back(c);
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) idle(gap - 1);
      strobe(seq[i]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rx_done_tick = 1'b0; din = 8'h00;
    idle(3);
    tests_run++;
    if ({pkt_valid, chk_err_tick, timeout_tick} !== 3'b000) begin
      fails++; $display("FAIL reset_pulses: got %b expected 000", {pkt_valid, chk_err_tick, timeout_tick});
    end
    tests_run++;
    if ({pkt_type, pkt_data} !== 40'h0) begin
      fails++; $display("FAIL reset_pkt: got %h/%h expected 00/00000000", pkt_type, pkt_data);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    int bv, be, bt;
    bv = n_valid; be = n_err; bt = n_tmo;
    send_frame(8'h01, 32'h12345678, 8'h09, 16);
    tests_run++;
    if (pkt_valid !== 1'b1) begin
      fails++; $display("FAIL good_valid_timing: got %b expected 1", pkt_valid);
    end
    tests_run++;
    if (pkt_type !== 8'h01 || pkt_data !== 32'h12345678) begin
      fails++; $display("FAIL good_values: got %h/%h expected 01/12345678", pkt_type, pkt_data);
    end
    idle(1);
    tests_run++;
    if (pkt_valid !== 1'b0) begin
      fails++; $display("FAIL good_valid_width: got %b expected 0", pkt_valid);
    end
    idle(3);
    tests_run++;
    if (n_valid - bv != 1 || n_err != be || n_tmo != bt) begin
      fails++; $display("FAIL good_counts: got v=%0d e=%0d t=%0d expected 1/0/0", n_valid - bv, n_err - be, n_tmo - bt);
    end
  endtask

  task automatic test_leading_junk();
    int bv, be;
    bv = n_valid; be = n_err;
    strobe(8'h00); idle(15);
    strobe(8'hFF); idle(15);
    strobe(8'h5A); idle(15);
    send_frame(8'h01, 32'h12345678, 8'h09, 16);
    idle(3);
    tests_run++;
    if (n_valid - bv != 1 || n_err != be) begin
      fails++; $display("FAIL junk_counts: got v=%0d e=%0d expected 1/0", n_valid - bv, n_err - be);
    end
    tests_run++;
    if (pkt_type !== 8'h01 || pkt_data !== 32'h12345678) begin
      fails++; $display("FAIL junk_values: got %h/%h expected 01/12345678", pkt_type, pkt_data);
    end
  endtask

  task automatic test_bad_checksum();
    int bv, be;
    bv = n_valid; be = n_err;
    send_frame(8'h01, 32'h12345678, 8'h08, 16);
    tests_run++;
    if (chk_err_tick !== 1'b1 || pkt_valid !== 1'b0) begin
      fails++; $display("FAIL badchk_pulse: got err=%b valid=%b expected 1/0", chk_err_tick, pkt_valid);
    end
    idle(3);
    tests_run++;
    if (n_err - be != 1 || n_valid != bv) begin
      fails++; $display("FAIL badchk_counts: got e=%0d v=%0d expected 1/0", n_err - be, n_valid - bv);
    end
    tests_run++;
    if (pkt_type !== 8'h01 || pkt_data !== 32'h12345678) begin
      fails++; $display("FAIL badchk_hold: got %h/%h expected 01/12345678", pkt_type, pkt_data);
    end
    bv = n_valid;
    send_frame(8'h02, 32'h000000A5, 8'hA7, 16);
    idle(3);
    tests_run++;
    if (n_valid - bv != 1 || pkt_type !== 8'h02 || pkt_data !== 32'h000000A5) begin
      fails++; $display("FAIL after_badchk: got v=%0d %h/%h expected 1 02/000000a5", n_valid - bv, pkt_type, pkt_data);
    end
  endtask

  task automatic test_timeout();
    int bt, bv;
    logic [DW-1:0] d;
    bt = n_tmo;
    strobe(8'hA5); idle(15);
    strobe(8'h01); idle(15);
    strobe(8'h12);
    idle(T - 1);
    tests_run++;
    if (timeout_tick !== 1'b0 || n_tmo != bt) begin
      fails++; $display("FAIL timeout_early: got tick=%b count=%0d expected 0/0", timeout_tick, n_tmo - bt);
    end
    idle(1);
    tests_run++;
    if (timeout_tick !== 1'b1) begin
      fails++; $display("FAIL timeout_tick: got %b expected 1 after %0d idle clocks", timeout_tick, T);
    end
    idle(1);
    tests_run++;
    if (timeout_tick !== 1'b0) begin
      fails++; $display("FAIL timeout_width: got %b expected 0", timeout_tick);
    end
    bv = n_valid;
    d = 32'($urandom);
    send_frame(8'h03, d, model_chk(8'h03, d), 16);
    idle(3);
    tests_run++;
    if (n_valid - bv != 1 || pkt_type !== 8'h03 || pkt_data !== d || n_tmo - bt != 1) begin
      fails++; $display("FAIL after_timeout: got v=%0d t=%0d %h/%h expected 1 1 03/%h", n_valid - bv, n_tmo - bt, pkt_type, pkt_data, d);
    end
  endtask

  task automatic test_expiry_race();
    int bt, bv;
    bt = n_tmo; bv = n_valid;
    // A gap of exactly T clocks puts each strobe in the timer's expiry cycle.
    send_frame(8'h44, 32'hCAFEF00D, model_chk(8'h44, 32'hCAFEF00D), T);
    idle(3);
    tests_run++;
    if (n_tmo != bt) begin
      fails++; $display("FAIL race_no_timeout: got %0d timeout pulses expected 0", n_tmo - bt);
    end
    tests_run++;
    if (n_valid - bv != 1 || pkt_type !== 8'h44 || pkt_data !== 32'hCAFEF00D) begin
      fails++; $display("FAIL race_frame: got v=%0d %h/%h expected 1 44/cafef00d", n_valid - bv, pkt_type, pkt_data);
    end
  endtask

  task automatic test_back_to_back();
    int bv, be;
    bv = n_valid; be = n_err;
    send_frame(8'h5E, 32'hA5A5A5A5, model_chk(8'h5E, 32'hA5A5A5A5), 1);
    tests_run++;
    if (pkt_valid !== 1'b1 || pkt_type !== 8'h5E || pkt_data !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL b2b_first: got %b %h/%h expected 1 5e/a5a5a5a5", pkt_valid, pkt_type, pkt_data);
    end
    // Sync immediately after the checksum byte.
    send_frame(8'h77, 32'h01020304, model_chk(8'h77, 32'h01020304), 1);
    idle(3);
    tests_run++;
    if (n_valid - bv != 2 || n_err != be || pkt_type !== 8'h77 || pkt_data !== 32'h01020304) begin
      fails++; $display("FAIL b2b_second: got v=%0d e=%0d %h/%h expected 2 0 77/01020304", n_valid - bv, n_err - be, pkt_type, pkt_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bv, be, bt;
    strobe(8'hA5); idle(3);
    strobe(8'h01); idle(3);
    strobe(8'h12); idle(3);
    strobe(8'h34);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (pkt_type !== 8'h00 || pkt_data !== 32'h0 || pkt_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset: got %b %h/%h expected 0 00/00000000", pkt_valid, pkt_type, pkt_data);
    end
    @(negedge clk);
    reset = 1'b0;
    bv = n_valid; be = n_err; bt = n_tmo;
    idle(2);
    strobe(8'h56); idle(3);
    strobe(8'h78); idle(3);
    strobe(8'h09);
    idle(T + 10);
    tests_run++;
    if (n_valid != bv || n_err != be || n_tmo != bt) begin
      fails++; $display("FAIL post_reset_ignore: got v=%0d e=%0d t=%0d expected 0/0/0", n_valid - bv, n_err - be, n_tmo - bt);
    end
    send_frame(8'h01, 32'h12345678, 8'h09, 4);
    idle(3);
    tests_run++;
    if (n_valid - bv != 1 || pkt_type !== 8'h01 || pkt_data !== 32'h12345678) begin
      fails++; $display("FAIL post_reset_frame: got v=%0d %h/%h expected 1 01/12345678", n_valid - bv, pkt_type, pkt_data);
    end
  endtask

  task automatic test_random();
    logic [7:0]    exp_type, t, c, j;
    logic [DW-1:0] exp_data, d;
    int exp_valid, exp_err, gap;
    bit bad;
    exp_type = pkt_type; exp_data = pkt_data;
    exp_valid = n_valid; exp_err = n_err;
    for (int k = 0; k < 20; k++) begin
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h3C;
        strobe(j);
        idle($urandom_range(0, 5));
      end
      t   = 8'($urandom);
      d   = 32'($urandom);
      gap = $urandom_range(1, 20);
      bad = ($urandom_range(0, 3) == 0);
      c   = model_chk(t, d);
      if (bad) c = c ^ 8'($urandom_range(1, 255));
      send_frame(t, d, c, gap);
      if (bad) begin
        exp_err++;
      end else begin
        exp_valid++;
        exp_type = t;
        exp_data = d;
      end
      idle(2);
      tests_run++;
      if (n_valid != exp_valid || n_err != exp_err) begin
        fails++; $display("FAIL rand_counts[%0d]: got v=%0d e=%0d expected v=%0d e=%0d", k, n_valid, n_err, exp_valid, exp_err);
      end
      tests_run++;
      if (pkt_type !== exp_type || pkt_data !== exp_data) begin
        fails++; $display("FAIL rand_values[%0d]: got %h/%h expected %h/%h", k, pkt_type, pkt_data, exp_type, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_leading_junk();
    test_bad_checksum();
    test_timeout();
    test_expiry_race();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
